alu_core_arbiter: RTL and testbench

- Round-robin scheduler that shares one mtm_Alu_core instance between NUM_REQ requesters.
- Accepts operand/opcode requests, drives the core's req/ack_in handshake and collects Result, ALUFlags, crc_out and OP_Err.
- Returns a tagged response to the owning requester.
- Detects core op-errors and hung transactions (timeout).

---
 rtl/alu_core_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_alu_core_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_core_arbiter.sv
// alu_core_arbiter
//   Round-robin scheduler sharing one mtm_Alu_core between NUM_REQ requesters.
//   One transaction is in flight at a time. A request is granted in IDLE,
//   issued to the core as a one-cycle req pulse, then the core result (or an
//   op-error / timeout) is returned to the owning requester as a tagged
//   response held until that requester accepts it.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   req_valid/ready   per-requester request handshake (ready is one-hot)
//   req_a/b/op        packed operands/opcode, requester i at [32i+31:32i] / [3i+2:3i]
//   rsp_valid/ready   per-requester response handshake (valid is one-hot)
//   rsp_result/flags/crc/err  captured core outputs; err 00 ok, 01 op error, 10 timeout
//   busy              high whenever the controller is not IDLE
//   core_*            connection to the shared ALU core (reset driven elsewhere)
module alu_core_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*32-1:0]   req_a,
  input  logic [NUM_REQ*32-1:0]   req_b,
  input  logic [NUM_REQ*3-1:0]    req_op,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [31:0]             rsp_result,
  output logic [3:0]              rsp_flags,
  output logic [2:0]              rsp_crc,
  output logic [1:0]              rsp_err,
  output logic                    busy,
  output logic                    core_req,
  output logic                    core_ack_in,
  output logic [31:0]             core_a,
  output logic [31:0]             core_b,
  output logic [2:0]              core_op,
  input  logic                    core_ack,
  input  logic                    core_op_err,
  input  logic [31:0]             core_result,
  input  logic [3:0]              core_flags,
  input  logic [2:0]              core_crc
);

  localparam int unsigned NR = NUM_REQ;
  localparam int unsigned OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LIMIT = WW'(TIMEOUT);

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_OP      = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state;
  logic [OW-1:0]   rr_ptr;
  logic [OW-1:0]   owner;
  logic [WW-1:0]   wait_cnt;

  logic            grant_found;
  logic [OW-1:0]   grant_idx;
  logic [31:0]     sel_a;
  logic [31:0]     sel_b;
  logic [2:0]      sel_op;
  int unsigned     cand;
  logic [NR-1:0]   owner_oh;
  logic            wait_live;

  // Round-robin search starting one past the last served requester.
  // The first hit wins; operands of the winner are muxed out in the same pass.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    sel_a       = '0;
    sel_b       = '0;
    sel_op      = '0;
    cand        = 0;
    for (int unsigned k = 1; k <= NR; k++) begin
      cand = (32'(rr_ptr) + k) % NR;
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = OW'(cand);
        sel_a       = req_a[cand*32 +: 32];
        sel_b       = req_b[cand*32 +: 32];
        sel_op      = req_op[cand*3 +: 3];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    owner_oh        = '0;
    owner_oh[owner] = 1'b1;
  end

  // The core's OP_Err lags req by more than one cycle, so the first WAIT
  // cycle still shows the previous transaction's status and is skipped.
  assign wait_live   = (state == S_WAIT) && (wait_cnt != '0);
  assign core_ack_in = wait_live && !core_op_err && core_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      wait_cnt   <= '0;
      core_a     <= '0;
      core_b     <= '0;
      core_op    <= '0;
      core_req   <= 1'b0;
      busy       <= 1'b0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_crc    <= '0;
      rsp_err    <= ERR_OK;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            core_a   <= sel_a;
            core_b   <= sel_b;
            core_op  <= sel_op;
            owner    <= grant_idx;
            core_req <= 1'b1;
            busy     <= 1'b1;
            state    <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          core_req <= 1'b0;
          rr_ptr   <= owner;
          wait_cnt <= '0;
          state    <= S_WAIT;
        end

        S_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (wait_live) begin
            if (core_op_err) begin
              rsp_err    <= ERR_OP;
              rsp_result <= '0;
              rsp_flags  <= '0;
              rsp_crc    <= '0;
              rsp_valid  <= owner_oh;
              state      <= S_RESP;
            end else if (core_ack) begin
              rsp_err    <= ERR_OK;
              rsp_result <= core_result;
              rsp_flags  <= core_flags;
              rsp_crc    <= core_crc;
              rsp_valid  <= owner_oh;
              state      <= S_RESP;
            end else if (wait_cnt == WAIT_LIMIT) begin
              rsp_err    <= ERR_TIMEOUT;
              rsp_result <= '0;
              rsp_flags  <= '0;
              rsp_crc    <= '0;
              rsp_valid  <= owner_oh;
              state      <= S_RESP;
            end
          end
        end

        S_RESP: begin
          if (rsp_ready[owner]) begin
            rsp_valid <= '0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  a_req_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
  a_rsp_valid_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(rsp_valid));
  a_core_req_pulse:   assert property (@(posedge clk) disable iff (rst) core_req |=> !core_req);

endmodule

// File: tb/tb_alu_core_arbiter.sv
// Self-checking bench for alu_core_arbiter with a behavioural ALU core model.
module tb_alu_core_arbiter;
  localparam int N  = 2;
  localparam int TO = 15;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*32-1:0] req_a, req_b;
  logic [N*3-1:0]  req_op;
  logic [31:0]     rsp_result;
  logic [3:0]      rsp_flags;
  logic [2:0]      rsp_crc;
  logic [1:0]      rsp_err;
  logic            busy, core_req, core_ack_in;
  logic [31:0]     core_a, core_b;
  logic [2:0]      core_op;
  logic            core_ack, core_op_err;
  logic [31:0]     core_result;
  logic [3:0]      core_flags;
  logic [2:0]      core_crc;

  always #5 clk = ~clk;

  alu_core_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_crc(rsp_crc), .rsp_err(rsp_err),
    .busy(busy), .core_req(core_req), .core_ack_in(core_ack_in),
    .core_a(core_a), .core_b(core_b), .core_op(core_op),
    .core_ack(core_ack), .core_op_err(core_op_err),
    .core_result(core_result), .core_flags(core_flags), .core_crc(core_crc)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit op_ok(input logic [2:0] op);
    return (op == 3'b000) || (op == 3'b001) || (op == 3'b100) || (op == 3'b101);
  endfunction

  // {result[31:0], flags{neg,zero,carry,ovf}, crc[2:0]}
  function automatic logic [38:0] alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    logic [32:0] w;
    logic [31:0] r;
    logic        c, v;
    logic [2:0]  crc;
    w = '0; c = 1'b0; v = 1'b0;
    case (op)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b100: begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32];
                    v = (a[31] == b[31]) && (r[31] != a[31]); end
      3'b101: begin w = {1'b0, a} - {1'b0, b}; r = w[31:0]; c = w[32];
                    v = (a[31] != b[31]) && (r[31] != a[31]); end
      default: r = '0;
    endcase
    crc = {^r[31:21], ^r[20:10], ^r[9:0]} ^ op;
    return {r, r[31], (r == 32'd0), c, v, crc};
  endfunction

  function automatic logic [N-1:0] oh(input int unsigned i);
    logic [N-1:0] m;
    m = '0;
    m[i] = 1'b1;
    return m;
  endfunction

  // ---------------- behavioural ALU core ----------------
  int unsigned cyc = 0;
  int unsigned cfg_delay = 3;
  bit          cfg_hang = 1'b0;
  int unsigned dly = 0;
  bit          stale = 1'b0;
  bit          upd = 1'b0;
  bit          pend_err = 1'b0;
  int unsigned ack_in_cnt = 0, ack_in_cyc = 0, core_req_cnt = 0, core_req_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rst) begin
      core_ack <= 1'b0; core_op_err <= 1'b0; core_result <= '0; core_flags <= '0;
      core_crc <= '0; dly <= 0; stale <= 1'b0; upd <= 1'b0; pend_err <= 1'b0;
    end else begin
      if (core_ack_in) begin
        ack_in_cnt <= ack_in_cnt + 1;
        ack_in_cyc <= cyc;
      end
      // OP_Err is refreshed one cycle after req, so it still shows the old value
      // during the controller's first WAIT cycle.
      if (upd) begin
        core_op_err <= pend_err;
        upd         <= 1'b0;
      end
      if (core_req) begin
        core_req_cnt <= core_req_cnt + 1;
        core_req_cyc <= cyc;
        core_ack <= 1'b0;
        stale    <= 1'b0;
        upd      <= 1'b1;
        pend_err <= !op_ok(core_op);
        if (op_ok(core_op)) begin
          {core_result, core_flags, core_crc} <= alu(core_a, core_b, core_op);
          dly <= cfg_hang ? 0 : cfg_delay;
        end else begin
          core_result <= $urandom;
          core_flags  <= 4'($urandom);
          core_crc    <= 3'($urandom);
          dly <= 0;
        end
      end else if (stale) begin
        core_ack <= 1'b0;
        stale    <= 1'b0;
      end else if (core_ack_in) begin
        stale <= 1'b1;
      end else if (dly == 1) begin
        core_ack <= 1'b1;
        dly      <= 0;
      end else if (dly > 1) begin
        dly <= dly - 1;
      end
    end
  end

  // ---------------- stimulus / reference ----------------
  logic [31:0] ta [N];
  logic [31:0] tb [N];
  logic [2:0]  top [N];
  int unsigned rr_m = 0;
  bit          lit_en = 1'b0;
  logic [31:0] lit_res;
  logic [3:0]  lit_flags;

  task automatic txn(input logic [N-1:0] mask, input int unsigned delay, input bit hang,
                     input int unsigned hold, output int unsigned w);
    int unsigned c0, t, a0, r0, exp_lat;
    logic [38:0] exp_v;
    logic [1:0]  exp_err;
    bit          exp_ack, hold_ok;
    w = 0;
    for (int unsigned k = N; k >= 1; k--) if (mask[(rr_m + k) % N]) w = (rr_m + k) % N;
    if (!op_ok(top[w])) begin
      exp_err = 2'b01; exp_v = '0; exp_lat = 4; exp_ack = 1'b0;
    end else if (hang || delay > TO) begin
      exp_err = 2'b10; exp_v = '0; exp_lat = 3 + TO; exp_ack = 1'b0;
    end else begin
      exp_err = 2'b00; exp_v = alu(ta[w], tb[w], top[w]); exp_lat = 3 + delay; exp_ack = 1'b1;
    end
    cfg_delay = delay;
    cfg_hang  = hang;
    for (int i = 0; i < N; i++) begin
      req_a[i*32 +: 32] = ta[i];
      req_b[i*32 +: 32] = tb[i];
      req_op[i*3 +: 3]  = top[i];
    end
    a0 = ack_in_cnt;
    r0 = core_req_cnt;
    req_valid = mask;
    rsp_ready = '0;
    #1;
    check("req_ready", 64'(req_ready), 64'(oh(w)));
    c0 = cyc;
    hold_ok = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      req_valid = '0;
      t = cyc - c0;
      if (core_a !== ta[w] || core_b !== tb[w] || core_op !== top[w]) hold_ok = 1'b0;
    end while (rsp_valid == '0 && t < 40);
    check("rsp_latency", 64'(t), 64'(exp_lat));
    check("core_operands_held", 64'(hold_ok), 64'd1);
    check("core_req_count", 64'(core_req_cnt - r0), 64'd1);
    check("core_req_cycle", 64'(core_req_cyc - c0), 64'd1);
    check("ack_in_count", 64'(ack_in_cnt - a0), 64'(exp_ack));
    if (exp_ack) check("ack_in_cycle", 64'(ack_in_cyc - c0), 64'(2 + delay));
    check("rsp_valid", 64'(rsp_valid), 64'(oh(w)));
    check("rsp_err", 64'(rsp_err), 64'(exp_err));
    check("rsp_data", {25'd0, rsp_result, rsp_flags, rsp_crc}, {25'd0, exp_v});
    check("busy_resp", 64'(busy), 64'd1);
    if (lit_en) begin
      check("lit_result", 64'(rsp_result), 64'(lit_res));
      check("lit_flags", 64'(rsp_flags), 64'(lit_flags));
    end
    for (int unsigned h = 0; h < hold; h++) begin
      rsp_ready = ~oh(w);
      @(negedge clk);
      check("rsp_hold_valid", 64'(rsp_valid), 64'(oh(w)));
      check("rsp_hold_data", {23'd0, rsp_err, rsp_result, rsp_flags, rsp_crc}, {23'd0, exp_err, exp_v});
    end
    rsp_ready = oh(w);
    @(negedge clk);
    rsp_ready = '0;
    check("rsp_released", 64'(rsp_valid), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);
    rr_m = w;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {16'd0, req_ready, rsp_valid, rsp_result, rsp_flags, rsp_crc, rsp_err,
                           busy, core_req, core_ack_in}, 64'd0);
    check({tag, "_core_a"}, 64'(core_a), 64'd0);
    check({tag, "_core_b"}, 64'(core_b), 64'd0);
    check({tag, "_core_op"}, 64'(core_op), 64'd0);
  endtask

  task automatic reset_during(input string tag, input logic [2:0] op, input int unsigned cycles,
                              input logic [N-1:0] pre_valid);
    ta[0] = 32'hDEAD_BEEF; tb[0] = 32'h1234_5678; top[0] = op;
    req_a[31:0] = ta[0]; req_b[31:0] = tb[0]; req_op[2:0] = top[0];
    cfg_delay = 10; cfg_hang = 1'b0;
    req_valid = 2'b01;
    repeat (cycles) begin
      @(negedge clk);
      req_valid = '0;
    end
    check({tag, "_pre_busy"}, 64'(busy), 64'd1);
    check({tag, "_pre_valid"}, 64'(rsp_valid), 64'(pre_valid));
    #2 rst = 1'b1;
    #1 check_all_zero(tag);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rr_m = 0;
    @(negedge clk);
    check_all_zero({tag, "_after"});
  endtask

  initial begin
    int unsigned w;
    logic [N-1:0] m;
    int unsigned seq [4];
    rst = 1'b1; req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0; req_op = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // both requesters valid continuously after reset: grants 1,0,1,0
    seq = '{1, 0, 1, 0};
    for (int i = 0; i < 4; i++) begin
      ta[0] = 32'(10 + i); tb[0] = 32'd7; top[0] = 3'b100;
      ta[1] = 32'(20 + i); tb[1] = 32'd3; top[1] = 3'b101;
      txn(2'b11, 3, 1'b0, 0, w);
      check("rr_order", 64'(w), 64'(seq[i]));
    end

    // AND from requester 0
    ta[0] = 32'hF0F0_0000; tb[0] = 32'hFF00_FF00; top[0] = 3'b000;
    lit_en = 1'b1; lit_res = 32'hF000_0000; lit_flags = 4'b1000;
    txn(2'b01, 3, 1'b0, 1, w);

    // ADD from requester 1
    ta[1] = 32'd1; tb[1] = 32'd2; top[1] = 3'b100;
    lit_res = 32'd3; lit_flags = 4'b0000;
    txn(2'b10, 3, 1'b0, 0, w);

    // invalid op, then a valid ADD must not see the sticky error
    ta[0] = 32'd9; tb[0] = 32'd9; top[0] = 3'b011;
    lit_res = 32'd0; lit_flags = 4'b0000;
    txn(2'b01, 3, 1'b0, 0, w);
    ta[0] = 32'd5; tb[0] = 32'd6; top[0] = 3'b100;
    lit_res = 32'd11; lit_flags = 4'b0000;
    txn(2'b01, 3, 1'b0, 0, w);

    // hung core, then ack exactly at the timeout boundary and just past it
    lit_res = 32'd0;
    ta[1] = 32'd7; tb[1] = 32'd8; top[1] = 3'b001;
    txn(2'b10, 3, 1'b1, 2, w);
    lit_en = 1'b0;
    txn(2'b10, TO, 1'b0, 0, w);
    txn(2'b10, TO + 1, 1'b0, 0, w);
    txn(2'b10, 1, 1'b0, 0, w);

    // asynchronous reset in WAIT and in RESP
    reset_during("rst_wait", 3'b100, 4, 2'b00);
    reset_during("rst_resp", 3'b011, 5, 2'b01);
    ta[0] = 32'd1; tb[0] = 32'd1; top[0] = 3'b100;
    ta[1] = 32'd2; tb[1] = 32'd2; top[1] = 3'b100;
    txn(2'b11, 2, 1'b0, 0, w);
    check("post_reset_winner", 64'(w), 64'd1);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      for (int j = 0; j < N; j++) begin
        ta[j] = $urandom; tb[j] = $urandom; top[j] = 3'($urandom_range(0, 7));
      end
      m = N'($urandom_range(1, (1 << N) - 1));
      txn(m, $urandom_range(1, TO + 3), ($urandom_range(0, 9) == 0), $urandom_range(0, 3), w);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
